fmap_drain: RTL and testbench

FMAP_DRAIN -- requirements
Module: fmap_drain

---
 rtl/cnn_pkg.sv | 17 +
 rtl/fmap_drain_if.sv | 26 ++
 rtl/fmap_addr_gen.sv | 94 +++++++++
 rtl/fmap_drain.sv | 105 ++++++++++
 tb/tb_fmap_drain.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath defaults and the feature-map drain state encoding.
package cnn_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned FMAP_W_DEF = 6;
    localparam int unsigned FMAP_H_DEF = 6;
    localparam int unsigned ADDR_W     = 6;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StEmit,
        StDone
    } drain_state_e;

endpackage

// File: rtl/fmap_drain_if.sv
// Feature-map RAM read port plus the outgoing valid/ready word stream.
interface fmap_drain_if
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic                     m_last;

    modport master (
        output rd_en, rd_addr, m_valid, m_data, m_last,
        input  rd_data, m_ready
    );

    modport slave (
        input  rd_en, rd_addr, m_valid, m_data, m_last,
        output rd_data, m_ready
    );

endinterface

// File: rtl/fmap_addr_gen.sv
// Output-position counters and raster RAM address generation for fmap_drain.
// FMAP_POOL_EN adds a 2x2 sub-sample index and stride-2 addressing.
module fmap_addr_gen
    import cnn_pkg::*;
#(
    parameter int unsigned FMAP_W = FMAP_W_DEF,
    parameter int unsigned FMAP_H = FMAP_H_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
`ifdef FMAP_POOL_EN
    input  logic              rd_step,
    output logic              first_rd,
`endif
    input  logic              word_step,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              last_rd,
    output logic              last_word
);

`ifdef FMAP_POOL_EN
    localparam int unsigned OUT_W = FMAP_W / 2;
    localparam int unsigned OUT_H = FMAP_H / 2;
`else
    localparam int unsigned OUT_W = FMAP_W;
    localparam int unsigned OUT_H = FMAP_H;
`endif

    localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] FMAP_W_A = ADDR_W'(FMAP_W);

    logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;

    assign last_word = (row_q == ROW_MAX) && (col_q == COL_MAX);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (word_step) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

`ifdef FMAP_POOL_EN
    // sub_q[0] selects the column, sub_q[1] the row inside the 2x2 window.
    logic [1:0] sub_q, sub_d;

    always_comb begin
        sub_d = sub_q;
        if (clear || word_step) begin
            sub_d = '0;
        end else if (rd_step && !last_rd) begin
            sub_d = sub_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= '0;
        end else begin
            sub_q <= sub_d;
        end
    end

    assign first_rd = (sub_q == 2'd0);
    assign last_rd  = (sub_q == 2'd3);
    assign rd_addr  = ((row_q << 1) + ADDR_W'(sub_q[1])) * FMAP_W_A
                    + (col_q << 1) + ADDR_W'(sub_q[0]);
`else
    assign last_rd = 1'b1;
    assign rd_addr = row_q * FMAP_W_A + col_q;
`endif

endmodule

// File: rtl/fmap_drain.sv
// Drains a convolution feature map from RAM onto a valid/ready stream.
// FMAP_POOL_EN selects 2x2 stride-2 max-pooling instead of pass-through.
module fmap_drain
    import cnn_pkg::*;
#(
    parameter int unsigned FMAP_W = FMAP_W_DEF,
    parameter int unsigned FMAP_H = FMAP_H_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    fmap_drain_if.master  bus,
    output logic          busy,
    output logic          done
);

    drain_state_e state_q, state_d;

    logic                     rd_en;
    logic                     rd_vld_q;
    logic                     last_rd;
    logic                     last_word;
    logic                     clear;
    logic                     word_step;
    logic signed [DATA_W-1:0] data_q;

    assign rd_en     = (state_q == StRead);
    assign clear     = (state_q == StIdle) && start;
    assign word_step = (state_q == StEmit) && bus.m_ready;

`ifdef FMAP_POOL_EN
    logic first_rd;
    logic first_q;
`endif

    fmap_addr_gen #(
        .FMAP_W (FMAP_W),
        .FMAP_H (FMAP_H)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
`ifdef FMAP_POOL_EN
        .rd_step   (rd_en),
        .first_rd  (first_rd),
`endif
        .word_step (word_step),
        .rd_addr   (bus.rd_addr),
        .last_rd   (last_rd),
        .last_word (last_word)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRead;
            StRead:  if (last_rd) state_d = StWait;
            StWait:  state_d = StEmit;
            StEmit:  if (bus.m_ready) state_d = last_word ? StDone : StRead;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // RAM data lands one cycle after its strobe; reads never overlap EMIT,
    // so data_q is stable for the whole time m_valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            data_q   <= '0;
`ifdef FMAP_POOL_EN
            first_q  <= 1'b0;
`endif
        end else begin
            rd_vld_q <= rd_en;
`ifdef FMAP_POOL_EN
            first_q  <= rd_en && first_rd;
            if (rd_vld_q && (first_q || (bus.rd_data > data_q))) begin
                data_q <= bus.rd_data;
            end
`else
            if (rd_vld_q) begin
                data_q <= bus.rd_data;
            end
`endif
        end
    end

    assign bus.rd_en   = rd_en;
    assign bus.m_valid = (state_q == StEmit);
    assign bus.m_data  = data_q;
    assign bus.m_last  = (state_q == StEmit) && last_word;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_fmap_drain.sv
// Directed self-checking bench for fmap_drain (pass-through, or pooled when
// FMAP_POOL_EN is defined).
module tb_fmap_drain;
    import cnn_pkg::*;

    localparam int W  = 6;
    localparam int H  = 6;
    localparam int DW = 32;
`ifdef FMAP_POOL_EN
    localparam int OW  = W / 2;
    localparam int OH  = H / 2;
    localparam int RPW = 4;
`else
    localparam int OW  = W;
    localparam int OH  = H;
    localparam int RPW = 1;
`endif
    localparam int NW       = OW * OH;
    localparam int NRD      = NW * RPW;
    localparam int PER_WORD = RPW + 2;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    fmap_drain_if #(.DATA_W(DW)) bus ();

    fmap_drain #(
        .FMAP_W (W),
        .FMAP_H (H),
        .DATA_W (DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] ram [64];

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [DW-1:0] words [$];
    int rd_cnt, done_cnt, done_cyc, first_hs, last_hs, last_cnt, last_idx;
    int stall_viol, stall_cyc, timeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [DW-1:0] exp_word(input int k);
`ifdef FMAP_POOL_EN
        int b;
        logic signed [DW-1:0] m;
        b = (2 * (k / OW)) * W + 2 * (k % OW);
        m = ram[b];
        if (ram[b + 1] > m) m = ram[b + 1];
        if (ram[b + W] > m) m = ram[b + W];
        if (ram[b + W + 1] > m) m = ram[b + W + 1];
        return m;
`else
        return ram[k];
`endif
    endfunction

    // Runs one frame from a start pulse and records what the stream did.
    task automatic drain(input bit stall, input int extra_at);
        int cyc;
        bit extra_done, prev_stall, fin;
        logic signed [DW-1:0] prev_data;
        logic prev_last;
        words.delete();
        rd_cnt = 0; done_cnt = 0; done_cyc = -1; first_hs = -1; last_hs = -1;
        last_cnt = 0; last_idx = -1; stall_viol = 0; stall_cyc = 0; timeout = 0;
        extra_done = 0; prev_stall = 0; prev_data = '0; prev_last = 0; fin = 0;
        bus.m_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!fin) begin
            // Roughly one ready cycle in three, not phase-locked to the word period.
            bus.m_ready = stall ? ((cyc % 5 == 0) || (cyc % 7 == 3)) : 1'b1;
            if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data
                               || bus.m_last !== prev_last)) stall_viol++;
            if (bus.m_last && !bus.m_valid) stall_viol++;
            if (bus.rd_en) rd_cnt++;
            if (bus.m_valid && !bus.m_ready) stall_cyc++;
            if (bus.m_valid && bus.m_ready) begin
                words.push_back(bus.m_data);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                if (bus.m_last) begin
                    last_cnt++;
                    last_idx = words.size() - 1;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
            if (extra_at >= 0 && !extra_done && words.size() == extra_at && bus.m_valid) begin
                start = 1'b1;
                extra_done = 1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
            if (done_cyc >= 0 && cyc > done_cyc + 4) fin = 1;
            if (cyc > 2000) begin
                timeout = 1;
                fin = 1;
            end
        end
        start = 1'b0;
        bus.m_ready = 1'b1;
    endtask

    task automatic check_frame(input string name);
        n_tests++;
        if (timeout !== 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got no done within bound, expected done", name);
        end
        n_tests++;
        if (words.size() !== NW) begin
            n_fail++;
            $display("FAIL %s_count: got %0d words, expected %0d", name, words.size(), NW);
        end
        for (int k = 0; k < NW && k < words.size(); k++) begin
            n_tests++;
            if (words[k] !== exp_word(k)) begin
                n_fail++;
                $display("FAIL %s_word%0d: got %0d, expected %0d", name, k, words[k], exp_word(k));
            end
        end
        n_tests++;
        if (last_cnt !== 1 || last_idx !== NW - 1) begin
            n_fail++;
            $display("FAIL %s_last: got %0d lasts at index %0d, expected 1 at %0d",
                     name, last_cnt, last_idx, NW - 1);
        end
        n_tests++;
        if (done_cnt !== 1 || done_cyc !== last_hs + 1) begin
            n_fail++;
            $display("FAIL %s_done: got %0d pulses at cycle %0d, expected 1 at %0d",
                     name, done_cnt, done_cyc, last_hs + 1);
        end
        n_tests++;
        if (rd_cnt !== NRD) begin
            n_fail++;
            $display("FAIL %s_reads: got %0d rd_en cycles, expected %0d", name, rd_cnt, NRD);
        end
        n_tests++;
        if (stall_viol !== 0) begin
            n_fail++;
            $display("FAIL %s_stable: got %0d hold violations, expected 0", name, stall_viol);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({bus.rd_en, bus.m_valid, bus.m_last, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 00000",
                     {bus.rd_en, bus.m_valid, bus.m_last, busy, done});
        end
        n_tests++;
        if (bus.rd_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d, expected 0", bus.rd_addr);
        end
        n_tests++;
        if (bus.m_data !== 32'sd0) begin
            n_fail++;
            $display("FAIL reset_data: got %0d, expected 0", bus.m_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 64; i++) ram[i] = i - 18;
        drain(1'b0, -1);
        check_frame("ramp");
        n_tests++;
        if (first_hs !== RPW + 1 || last_hs - first_hs !== PER_WORD * (NW - 1)) begin
            n_fail++;
            $display("FAIL ramp_rate: got first %0d span %0d, expected first %0d span %0d",
                     first_hs, last_hs - first_hs, RPW + 1, PER_WORD * (NW - 1));
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 64; i++) ram[i] = i - 18;
        drain(1'b1, -1);
        check_frame("bp");
        n_tests++;
        if (stall_cyc < 1) begin
            n_fail++;
            $display("FAIL bp_stalled: got %0d stalled cycles, expected at least 1", stall_cyc);
        end
    endtask

    task automatic test_latency();
        int cyc;
        bus.m_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (bus.rd_addr !== 6'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_addr: got addr %0d busy %b, expected addr 0 busy 1",
                     bus.rd_addr, busy);
        end
        for (int i = 0; i <= RPW + 1; i++) begin
            n_tests++;
            if (bus.rd_en !== (i < RPW) || bus.m_valid !== (i == RPW + 1)) begin
                n_fail++;
                $display("FAIL lat_cyc%0d: got rd_en %b m_valid %b, expected %b %b",
                         i, bus.rd_en, bus.m_valid, i < RPW, i == RPW + 1);
            end
            if (i <= RPW) tick();
        end
        cyc = 0;
        while (!done && cyc < 1000) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_finish: got done %b, expected 1", done);
        end
        // A start landing in the DONE cycle must not launch another frame.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL start_in_done%0d: got busy %b, expected 0", i, busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int hs, cyc, bad;
        for (int i = 0; i < 64; i++) ram[i] = i - 18;
        hs = 0;
        cyc = 0;
        bus.m_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (hs < 5 && cyc < 500) begin
            if (bus.m_valid && bus.m_ready) hs++;
            tick();
            cyc++;
        end
        n_tests++;
        if (hs !== 5) begin
            n_fail++;
            $display("FAIL rstmid_words: got %0d words, expected 5", hs);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if ({bus.m_valid, busy, bus.rd_en} !== 3'b0 || bus.m_data !== 32'sd0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got valid/busy/rd_en %b data %0d, expected 000 0",
                     {bus.m_valid, busy, bus.rd_en}, bus.m_data);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.rd_en || bus.m_valid || busy) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got %0d active cycles, expected 0", bad);
        end
        drain(1'b0, -1);
        n_tests++;
        if (words.size() < 1 || words[0] !== ram[0 + 0 * W]
`ifdef FMAP_POOL_EN
            + 0 + (ram[W + 1] - ram[0])
`endif
            ) begin
            n_fail++;
            $display("FAIL rstmid_first: got %0d, expected %0d",
                     words.size() > 0 ? words[0] : 32'sd0, exp_word(0));
        end
        check_frame("rstmid");
    endtask

    task automatic test_alt_sign();
        for (int i = 0; i < 64; i++) ram[i] = (i % 2 != 0) ? -i : i;
        drain(1'b0, -1);
        check_frame("alt");
`ifdef FMAP_POOL_EN
        n_tests++;
        if (words.size() < 1 || words[0] !== 32'sd6) begin
            n_fail++;
            $display("FAIL pool_first: got %0d, expected 6",
                     words.size() > 0 ? words[0] : 32'sd0);
        end
`endif
    endtask

    task automatic test_start_busy();
        for (int i = 0; i < 64; i++) ram[i] = i - 18;
        drain(1'b0, 2);
        check_frame("busystart");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.m_ready = 1'b1;
        test_reset();
        test_ramp();
        test_backpressure();
        test_latency();
        test_reset_mid();
        test_alt_sign();
        test_start_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
